vote_window_accumulator: RTL
============================

Name: vote_window_accumulator

Overview:
- Downstream consumer of the 5-input combinational vote adder, which produces a 3-bit sum in the range 0..5.
- Accepts one sum per cycle over a valid/ready handshake and accumulates WINDOW samples.
- Emits the window total, a majority flag and a range-error flag over a second valid/ready handshake.
- Sits between the vote adder and the decision/logging logic.

Parameters:
- WINDOW, 8: samples per window; legal range >= 1.
- SUM_W, 3: width of the incoming sum.
- ACC_W, 6: accumulator/total width; WINDOW*5 must be < 2**ACC_W (elaboration-time check).
- THRESH, 20: the majority flag asserts when total >= THRESH.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- clear  in  1  synchronous flush of the current window and any held result
- in_valid  in  1  upstream sum valid
- in_ready  out  1  block can accept a sum
- in_sum  in  SUM_W  vote sum, legal 0..5
- out_valid  out  1  window result valid
- out_ready  in  1  downstream accepts the result
- out_total  out  ACC_W  sum of the WINDOW clamped samples
- out_major  out  1  out_total >= THRESH
- out_err  out  1  at least one sample in the window was > 5

Behaviour:
- One clock domain, clk. Reset is synchronous and active-low (rst_n). Nothing asynchronous.
- Reset:
  - state = IDLE; acc, cnt and the sticky error are 0.
  - out_valid, out_total, out_major and out_err are 0.
  - in_ready is 0 during any cycle in which rst_n = 0.
- States:
  - IDLE: acc = 0, cnt = 0.
  - ACCUM: window in progress.
  - HOLD: result presented.
- in_ready is 1 in IDLE and ACCUM (rst_n = 1, clear = 0) and 0 in HOLD. It is a registered-state decode with no combinational path from out_ready.
- A transfer occurs when in_valid & in_ready. The sample value is min(in_sum, 5). If in_sum > 5, the sticky error is set.
- IDLE -> ACCUM on the first transfer: acc = sample, cnt = 1.
- ACCUM: each transfer does acc += sample, cnt += 1.
- Window close: the transfer with cnt == WINDOW-1 (or the first transfer when WINDOW = 1) closes the window:
  - out_total = acc + sample; out_major = (out_total >= THRESH); out_err = sticky error OR'd with the current sample's error.
  - The registered outputs change one cycle after the final sample is accepted; out_valid = 1 in that same cycle.
  - state -> HOLD; acc, cnt and the sticky error are cleared.
- HOLD:
  - The outputs stay stable while out_valid & !out_ready (back-pressure holds indefinitely).
  - On out_valid & out_ready: the next cycle has out_valid = 0, state = IDLE and in_ready = 1.
  - Result outputs keep their last value after out_valid falls.
- Throughput: one window per WINDOW+1 cycles when out_ready is held high.
- Gaps (in_valid = 0) in ACCUM leave acc and cnt unchanged. There is no timeout.
- clear = 1: the next state is IDLE; acc, cnt, the sticky error and out_valid are all 0. Any held result is discarded. clear has priority over all transfers in the same cycle, including the final-sample transfer and the output handshake.
- Arithmetic is unsigned. The accumulator cannot overflow given the ACC_W constraint.
- THRESH > WINDOW*5 means out_major never asserts; this is legal.

Optional Feature:
- Macro: VOTE_WINDOW_MINMAX_EN.
- When defined:
  - Adds outputs out_min [SUM_W] and out_max [SUM_W]: the minimum and maximum clamped sample in the window.
  - They are registered and updated alongside out_total, and reset/cleared to min = 5, max = 0 while tracking.
  - They present the window values with out_valid and are 0 after reset.
- When undefined: the ports and the tracking logic are absent. All other behaviour is identical.

Decomposition:
- Package vote_window_pkg holds:
  - typedef enum of the state (IDLE, ACCUM, HOLD);
  - localparam MAX_VOTE_SUM = 5;
  - function clamp_sum returning min(x, MAX_VOTE_SUM) and an error bit.
- One sub-module, vote_minmax_track, is instantiated only under VOTE_WINDOW_MINMAX_EN. Inputs: clk, rst_n, clear, sample, sample_valid, window_close. Outputs: min, max.

Test Plan:
- Reset held for 3 cycles with in_valid = 1: in_ready = 0 and out_valid = 0 throughout; no accumulation after rst_n rises.
- WINDOW = 8, samples 3,3,3,3,3,3,3,3 back-to-back with out_ready = 1: out_valid pulses once, one cycle after the 8th accept; out_total = 24, out_major = 1, out_err = 0.
- Samples 1,2,0,5,1,1,0,2 with 2-cycle gaps between samples, out_ready = 0 for 4 cycles: out_total = 12 and out_major = 0, held stable. in_ready = 0 until out_ready = 1, then IDLE.
- One sample of 7 among the others (e.g. 7,0,0,0,0,0,0,0): out_total = 5 and out_err = 1. The next window of all-zero samples has out_err = 0 and out_total = 0.
- clear asserted on the cycle of the 8th accept, and separately clear asserted during HOLD: no out_valid in the first case; out_valid drops next cycle in the second. The following window accumulates from 0.
- With VOTE_WINDOW_MINMAX_EN and samples 4,1,5,2,2,3,0,4: out_min = 0, out_max = 5, out_total = 21, out_major = 1.

Source files
------------

// File: rtl/vote_window_accumulator_pkg.sv
// Shared types and helpers for the vote window accumulator slice.
// Optional min/max tracking is enabled with VOTE_WINDOW_MINMAX_EN.
package vote_window_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int unsigned MAX_VOTE_SUM = 5;

  typedef struct packed {
    logic [2:0] val;
    logic       err;
  } clamp_t;

  // A 5-input adder can never legally exceed 5; anything larger is saturated and flagged.
  function automatic clamp_t clamp_sum(input logic [31:0] x);
    clamp_t r;
    if (x > MAX_VOTE_SUM) begin
      r.val = 3'(MAX_VOTE_SUM);
      r.err = 1'b1;
    end else begin
      r.val = x[2:0];
      r.err = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/vote_window_accumulator_if.sv
// Sample-in / window-result-out bus of the vote window accumulator.
// out_min/out_max exist only when VOTE_WINDOW_MINMAX_EN is defined.
interface vote_window_accumulator_if #(
  parameter int SUM_W = 3,
  parameter int ACC_W = 6
);
  // Both channels: a beat moves on a rising clk edge where valid & ready are both 1;
  // the source holds valid and payload steady until that edge, and ready never waits on valid.
  logic             in_valid;
  logic             in_ready;
  logic [SUM_W-1:0] in_sum;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_total;
  logic             out_major;
  logic             out_err;
`ifdef VOTE_WINDOW_MINMAX_EN
  logic [SUM_W-1:0] out_min;
  logic [SUM_W-1:0] out_max;

  modport master (
    output in_valid, in_sum, out_ready,
    input  in_ready, out_valid, out_total, out_major, out_err, out_min, out_max
  );

  modport slave (
    input  in_valid, in_sum, out_ready,
    output in_ready, out_valid, out_total, out_major, out_err, out_min, out_max
  );
`else
  modport master (
    output in_valid, in_sum, out_ready,
    input  in_ready, out_valid, out_total, out_major, out_err
  );

  modport slave (
    input  in_valid, in_sum, out_ready,
    output in_ready, out_valid, out_total, out_major, out_err
  );
`endif
endinterface

// File: rtl/vote_window_accumulator_minmax_track.sv
// Running min/max of the clamped samples in a window, latched at window close.
// Only instantiated when VOTE_WINDOW_MINMAX_EN is defined.
module vote_minmax_track
  import vote_window_pkg::*;
#(
  parameter int SUM_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [SUM_W-1:0] sample,
  input  logic             sample_valid,
  input  logic             window_close,
  output logic [SUM_W-1:0] min,
  output logic [SUM_W-1:0] max
);

  localparam logic [SUM_W-1:0] MIN_INIT = SUM_W'(MAX_VOTE_SUM);
  localparam logic [SUM_W-1:0] MAX_INIT = '0;

  logic [SUM_W-1:0] trk_min_q, trk_min_d;
  logic [SUM_W-1:0] trk_max_q, trk_max_d;
  logic [SUM_W-1:0] min_q, min_d;
  logic [SUM_W-1:0] max_q, max_d;
  logic [SUM_W-1:0] nxt_min;
  logic [SUM_W-1:0] nxt_max;

  always_comb begin
    nxt_min   = (sample < trk_min_q) ? sample : trk_min_q;
    nxt_max   = (sample > trk_max_q) ? sample : trk_max_q;
    trk_min_d = trk_min_q;
    trk_max_d = trk_max_q;
    min_d     = min_q;
    max_d     = max_q;
    if (clear) begin
      trk_min_d = MIN_INIT;
      trk_max_d = MAX_INIT;
    end else if (sample_valid) begin
      if (window_close) begin
        // The closing sample is folded in directly so the result lands with out_total.
        min_d     = nxt_min;
        max_d     = nxt_max;
        trk_min_d = MIN_INIT;
        trk_max_d = MAX_INIT;
      end else begin
        trk_min_d = nxt_min;
        trk_max_d = nxt_max;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      trk_min_q <= MIN_INIT;
      trk_max_q <= MAX_INIT;
      min_q     <= '0;
      max_q     <= '0;
    end else begin
      trk_min_q <= trk_min_d;
      trk_max_q <= trk_max_d;
      min_q     <= min_d;
      max_q     <= max_d;
    end
  end

  assign min = min_q;
  assign max = max_q;

endmodule

// File: rtl/vote_window_accumulator.sv
// Accumulates WINDOW clamped vote sums and presents total/majority/error per window.
// Defining VOTE_WINDOW_MINMAX_EN adds per-window min/max outputs.
module vote_window_accumulator
  import vote_window_pkg::*;
#(
  parameter int WINDOW = 8,
  parameter int SUM_W  = 3,
  parameter int ACC_W  = 6,
  parameter int THRESH = 20
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  vote_window_accumulator_if.slave  bus,
  output state_t                    dbg_state
);

  localparam int CNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WINDOW - 1);

  if (WINDOW < 1 || (WINDOW * 5) >= (1 << ACC_W)) begin : g_param_check
    $error("vote_window_accumulator: WINDOW must be >= 1 and WINDOW*5 < 2**ACC_W");
  end

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [ACC_W-1:0] total_q, total_d;
  logic             major_q, major_d;
  logic             oerr_q, oerr_d;

  clamp_t           cl;
  logic [SUM_W-1:0] sample;
  logic [ACC_W-1:0] sum_full;
  logic             in_ready;
  logic             out_valid;
  logic             xfer;
  logic             win_close;

  assign cl        = clamp_sum(32'(bus.in_sum));
  assign sample    = SUM_W'(cl.val);
  assign sum_full  = acc_q + ACC_W'(sample);
  assign xfer      = bus.in_valid & in_ready;
  assign win_close = xfer & (cnt_q == LAST_CNT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (xfer) state_d = win_close ? HOLD : ACCUM;
        ACCUM:   if (win_close) state_d = HOLD;
        HOLD:    if (bus.out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // in_ready is a pure state decode; clear and reset block intake in the same cycle.
  always_comb begin
    in_ready  = rst_n & ~clear & (state_q != HOLD);
    out_valid = (state_q == HOLD);
  end

  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    total_d = total_q;
    major_d = major_q;
    oerr_d  = oerr_q;
    if (clear) begin
      acc_d = '0;
      cnt_d = '0;
      err_d = 1'b0;
    end else if (xfer) begin
      if (win_close) begin
        total_d = sum_full;
        major_d = (32'(sum_full) >= 32'(THRESH));
        oerr_d  = err_q | cl.err;
        acc_d   = '0;
        cnt_d   = '0;
        err_d   = 1'b0;
      end else begin
        acc_d = sum_full;
        cnt_d = cnt_q + 1'b1;
        err_d = err_q | cl.err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      total_q <= '0;
      major_q <= 1'b0;
      oerr_q  <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      total_q <= total_d;
      major_q <= major_d;
      oerr_q  <= oerr_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_total = total_q;
  assign bus.out_major = major_q;
  assign bus.out_err   = oerr_q;
  assign dbg_state     = state_q;

`ifdef VOTE_WINDOW_MINMAX_EN
  vote_minmax_track #(
    .SUM_W (SUM_W)
  ) u_minmax (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .sample       (sample),
    .sample_valid (xfer),
    .window_close (win_close),
    .min          (bus.out_min),
    .max          (bus.out_max)
  );
`endif

endmodule
